// File: rtl/line_rx_pkg.sv
// Shared definitions for the oversampling line receiver: verify-mode codes,
// FSM state encoding and a constant clog2 helper.
package line_rx_pkg;

  localparam logic [1:0] VERIFY_EVEN = 2'b00;
  localparam logic [1:0] VERIFY_ODD  = 2'b01;
  localparam logic [1:0] VERIFY_NONE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2
  } rx_state_e;

  // Ceiling log2 for sizing counters and pointers; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/line_rx_sfifo.sv
// Synchronous FIFO with push/pop, full/empty and occupancy level.
// A push while full is accepted only if a pop happens in the same cycle.
module line_rx_sfifo
  import line_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [clog2(DEPTH):0] o_level
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign o_full  = (level_q == (AW + 1)'(DEPTH));
  assign o_empty = (level_q == '0);
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_rdata = mem_q[rd_ptr_q];
  assign o_level = level_q;

  // Pointer and occupancy update; pointers wrap naturally at power-of-2 depth.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer registers; reset flushes the FIFO.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array.
  always_ff @(posedge i_clk) begin
    // NOTE: storage is not reset; entries are only visible through the reset pointers.
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/line_rx_fifo_ovs.sv
// Oversampling asynchronous serial receiver with receive FIFO, sticky
// parity/frame/overrun flags and a level interrupt.
// Optional build macro LINE_RX_MAJORITY_EN: decide each bit by a 2-of-3 vote
// of the samples around the bit centre instead of a single sample.
module line_rx_fifo_ovs
  import line_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int INT_LEVEL  = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_tick,
  input  logic                       i_rx_data,
  input  logic [1:0]                 i_verify_mode,
  input  logic                       i_stop2,
  input  logic                       i_ce_n,
  input  logic                       i_rd,
  input  logic                       i_clear_int_n,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_valid,
  output logic [clog2(FIFO_DEPTH):0] o_level,
  output logic                       o_busy,
  output logic                       o_err_parity,
  output logic                       o_err_frame,
  output logic                       o_err_overrun,
  output logic                       o_rx_int
);

  localparam int TICK_W    = clog2(OVS);
  localparam int BIT_W     = clog2(DATA_W);
  localparam int LVL_W     = clog2(FIFO_DEPTH) + 1;
  localparam int LAST_TICK = OVS - 1;
`ifdef LINE_RX_MAJORITY_EN
  localparam int DEC_TICK  = OVS / 2;
`else
  localparam int DEC_TICK  = OVS / 2 - 1;
`endif

  rx_state_e         state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [1:0]        mode_q, mode_d;
  logic              stop2_q, stop2_d;
  logic              par_bad_q, par_bad_d, frm_bad_q, frm_bad_d;
  logic              err_par_q, err_par_d, err_frm_q, err_frm_d, err_ovr_q, err_ovr_d;
  logic              line_bit, start_edge, at_centre;
  logic              fin, fin_par, fin_frm, push_req, overrun_evt;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

`ifdef LINE_RX_MAJORITY_EN
  logic [1:0]        samp_q, samp_d;
  // Majority of the current and two previous tick samples.
  assign line_bit = (sync2_q & samp_q[0]) | (sync2_q & samp_q[1]) | (samp_q[0] & samp_q[1]);
`else
  assign line_bit = sync2_q;
`endif

  assign start_edge = hist_q & ~sync2_q;
  assign at_centre  = (tick_cnt_q == TICK_W'(LAST_TICK));

  // Input synchroniser every clock; history and vote samples only on ticks.
  always_comb begin
    sync1_d = i_rx_data;
    sync2_d = sync1_q;
    hist_d  = i_tick ? sync2_q : hist_q;
`ifdef LINE_RX_MAJORITY_EN
    samp_d  = i_tick ? {samp_q[0], sync2_q} : samp_q;
`endif
  end

  // Frame FSM: next state, counters, shift register and per-frame error state.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    mode_d     = mode_q;
    stop2_d    = stop2_q;
    par_bad_d  = par_bad_q;
    frm_bad_d  = frm_bad_q;
    fin        = 1'b0;
    fin_par    = 1'b0;
    fin_frm    = 1'b0;
    if (i_tick) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          tick_cnt_d = '0;
          if (start_edge && !i_ce_n) begin
            state_d   = START;
            mode_d    = i_verify_mode;
            stop2_d   = i_stop2;
            bit_cnt_d = '0;
            par_bad_d = 1'b0;
            frm_bad_d = 1'b0;
          end
        end
        START: begin
          if (tick_cnt_q == TICK_W'(DEC_TICK)) begin
            tick_cnt_d = '0;
            state_d    = line_bit ? IDLE : DATA;
          end
        end
        DATA: begin
          if (at_centre) begin
            tick_cnt_d = '0;
            shift_d    = {line_bit, shift_q[DATA_W-1:1]};
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              bit_cnt_d = '0;
              state_d   = mode_q[1] ? STOP : PARITY;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (at_centre) begin
            tick_cnt_d = '0;
            par_bad_d  = ((^shift_q) ^ line_bit) != mode_q[0];
            state_d    = STOP;
          end
        end
        STOP, STOP2: begin
          if (at_centre) begin
            tick_cnt_d = '0;
            if (state_q == STOP && stop2_q) begin
              frm_bad_d = frm_bad_q | ~line_bit;
              state_d   = STOP2;
            end else begin
              fin     = 1'b1;
              fin_par = par_bad_q;
              fin_frm = frm_bad_q | ~line_bit;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign push_req    = fin & ~fin_par & ~fin_frm;
  assign overrun_evt = push_req & fifo_full & ~i_rd;

  // Sticky error flags: cleared while i_clear_int_n is low, a same-cycle set wins.
  always_comb begin
    err_par_d = (err_par_q & i_clear_int_n) | fin_par;
    err_frm_d = (err_frm_q & i_clear_int_n) | fin_frm;
    err_ovr_d = (err_ovr_q & i_clear_int_n) | overrun_evt;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      hist_q     <= 1'b1;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      mode_q     <= VERIFY_NONE;
      stop2_q    <= 1'b0;
      par_bad_q  <= 1'b0;
      frm_bad_q  <= 1'b0;
      err_par_q  <= 1'b0;
      err_frm_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
`ifdef LINE_RX_MAJORITY_EN
      samp_q     <= 2'b11;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      hist_q     <= hist_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      mode_q     <= mode_d;
      stop2_q    <= stop2_d;
      par_bad_q  <= par_bad_d;
      frm_bad_q  <= frm_bad_d;
      err_par_q  <= err_par_d;
      err_frm_q  <= err_frm_d;
      err_ovr_q  <= err_ovr_d;
`ifdef LINE_RX_MAJORITY_EN
      samp_q     <= samp_d;
`endif
    end
  end

  line_rx_sfifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push_req),
    .i_wdata (shift_q),
    .i_pop   (i_rd),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  assign o_valid       = ~fifo_empty;
  assign o_data        = fifo_empty ? '0 : fifo_rdata;
  assign o_busy        = (state_q != IDLE);
  assign o_err_parity  = err_par_q;
  assign o_err_frame   = err_frm_q;
  assign o_err_overrun = err_ovr_q;
  assign o_rx_int      = (o_level >= LVL_W'(INT_LEVEL)) | err_par_q | err_frm_q | err_ovr_q;

endmodule

// File: tb/tb_line_rx_fifo_ovs.sv
// Self-checking bench for line_rx_fifo_ovs: serial frames are built from the
// framing rules, expected words go into a scoreboard queue and a monitor pops
// and compares whenever the receiver presents a word.
module tb_line_rx_fifo_ovs;
  import line_rx_pkg::*;

  localparam int DATA_W     = 8;
  localparam int OVS        = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int INT_LEVEL  = 1;
  localparam int LVL_W      = clog2(FIFO_DEPTH) + 1;
  localparam int TDIV       = 2;            // clocks per tick
  localparam int BIT_CLK    = TDIV * OVS;   // clocks per bit
`ifdef LINE_RX_MAJORITY_EN
  localparam int DEC_TICK   = OVS / 2;
`else
  localparam int DEC_TICK   = OVS / 2 - 1;
`endif

  logic              i_clk, i_rst_n, i_tick, i_rx_data, i_stop2, i_ce_n, i_rd, i_clear_int_n;
  logic [1:0]        i_verify_mode;
  logic [DATA_W-1:0] o_data;
  logic              o_valid, o_busy, o_err_parity, o_err_frame, o_err_overrun, o_rx_int;
  logic [LVL_W-1:0]  o_level;

  logic              rd_en, rd_a, rd_b;
  logic              exp_par, exp_frm, exp_ovr;
  logic [DATA_W-1:0] exp_q [$];
  int                n_checks, n_pass;
  event              fall_ev;

  assign i_rd = rd_a | rd_b;

  line_rx_fifo_ovs #(
    .DATA_W (DATA_W), .OVS (OVS), .FIFO_DEPTH (FIFO_DEPTH), .INT_LEVEL (INT_LEVEL)
  ) dut (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .i_tick (i_tick), .i_rx_data (i_rx_data),
    .i_verify_mode (i_verify_mode), .i_stop2 (i_stop2), .i_ce_n (i_ce_n), .i_rd (i_rd),
    .i_clear_int_n (i_clear_int_n), .o_data (o_data), .o_valid (o_valid), .o_level (o_level),
    .o_busy (o_busy), .o_err_parity (o_err_parity), .o_err_frame (o_err_frame),
    .o_err_overrun (o_err_overrun), .o_rx_int (o_rx_int)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // One-cycle tick every TDIV clocks.
  initial begin
    i_tick = 1'b0;
    forever begin
      @(negedge i_clk);
      i_tick = ~i_tick;
    end
  end

  initial begin
    repeat (80000) @(posedge i_clk);
    $display("FAIL watchdog: bench did not finish (passed %0d of %0d)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: whenever a word is presented and reading is enabled, compare and pop it.
  initial begin
    rd_a = 1'b0;
    forever begin
      @(negedge i_clk);
      #1;
      if (rd_en && o_valid) begin
        if (exp_q.size() == 0) check("unexpected_word", o_valid, 1'b0);
        else check("rx_word", o_data, exp_q.pop_front());
        rd_a = 1'b1;
        @(negedge i_clk);
        #1;
        rd_a = 1'b0;
      end
    end
  end

  // Clocks from the line falling edge until the cycle that ends on the last stop centre.
  function automatic int fin_cycles(input logic [1:0] mode, input logic stop2);
    int nbits;
    nbits = DATA_W + (mode[1] ? 0 : 1) + (stop2 ? 2 : 1);
    return 2 + TDIV * (DEC_TICK + 1) + BIT_CLK * nbits;
  endfunction

  // Drive one frame; the falling edge is placed just before a tick edge.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic [1:0] mode,
                            input logic stop2, input logic bad_par, input logic bad_stop);
    logic bits [16];
    int   nb;
    nb = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < DATA_W; i++) bits[nb++] = d[i];
    if (!mode[1]) bits[nb++] = (^d) ^ mode[0] ^ bad_par;
    if (stop2) bits[nb++] = 1'b1;
    bits[nb++] = ~bad_stop;
    i_verify_mode = mode;
    i_stop2       = stop2;
    @(negedge i_clk);
    #1;
    while (!i_tick) begin
      @(negedge i_clk);
      #1;
    end
    for (int i = 0; i < nb; i++) begin
      i_rx_data = bits[i];
      if (i == 0) -> fall_ev;
      repeat (BIT_CLK) @(negedge i_clk);
      #1;
    end
    i_rx_data = 1'b1;
    repeat (BIT_CLK) @(negedge i_clk);
    #1;
  endtask

  // Reference model update for one frame, then send it.
  task automatic issue(input logic [DATA_W-1:0] d, input logic [1:0] mode,
                       input logic stop2, input logic bad_par, input logic bad_stop);
    logic par_err;
    par_err = bad_par && !mode[1];
    if (par_err) exp_par = 1'b1;
    if (bad_stop) exp_frm = 1'b1;
    if (!par_err && !bad_stop) begin
      if (!rd_en && exp_q.size() >= FIFO_DEPTH) exp_ovr = 1'b1;
      else exp_q.push_back(d);
    end
    send_frame(d, mode, stop2, bad_par, bad_stop);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_err_parity"}, o_err_parity, exp_par);
    check({tag, "_err_frame"}, o_err_frame, exp_frm);
    check({tag, "_err_overrun"}, o_err_overrun, exp_ovr);
  endtask

  task automatic check_level(input string tag);
    check({tag, "_level"}, o_level, exp_q.size());
    check({tag, "_rx_int"}, o_rx_int,
          (exp_q.size() >= INT_LEVEL) || exp_par || exp_frm || exp_ovr);
  endtask

  task automatic clear_flags();
    @(negedge i_clk);
    #1;
    i_clear_int_n = 1'b0;
    @(negedge i_clk);
    #1;
    i_clear_int_n = 1'b1;
    exp_par = 1'b0;
    exp_frm = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n     = 0;
    rd_en = 1'b1;
    while ((exp_q.size() != 0 || o_valid) && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    repeat (2) @(negedge i_clk);
    #1;
    check({tag, "_drain_queue"}, exp_q.size(), 0);
    check({tag, "_drain_level"}, o_level, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_level"}, o_level, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_flags"}, {o_err_parity, o_err_frame, o_err_overrun}, 0);
    check({tag, "_rx_int"}, o_rx_int, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] w, head;
    n_checks = 0; n_pass = 0;
    rd_en = 1'b0; rd_b = 1'b0;
    exp_par = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
    i_rst_n = 1'b0; i_rx_data = 1'b1; i_verify_mode = VERIFY_NONE; i_stop2 = 1'b0;
    i_ce_n = 1'b0; i_clear_int_n = 1'b1;
    repeat (4) @(negedge i_clk);
    #1;
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    repeat (BIT_CLK) @(negedge i_clk);

    // 1: plain frame, exact push timing.
    fork
      issue(8'hA5, VERIFY_NONE, 1'b0, 1'b0, 1'b0);
      begin
        @(fall_ev);
        repeat (fin_cycles(VERIFY_NONE, 1'b0)) @(negedge i_clk);
        #1;
        check("t1_valid_before_push", o_valid, 1'b0);
        @(negedge i_clk);
        #1;
        check("t1_valid", o_valid, 1'b1);
        check("t1_data", o_data, 8'hA5);
        check("t1_rx_int", o_rx_int, 1'b1);
      end
    join
    check_flags("t1");
    drain("t1");

    // 2: even parity good/bad, odd parity good.
    rd_en = 1'b0;
    issue(8'h37, VERIFY_EVEN, 1'b0, 1'b0, 1'b0);
    check_level("t2_even_ok");
    issue(8'h37, VERIFY_EVEN, 1'b0, 1'b1, 1'b0);
    check_flags("t2_even_bad");
    check_level("t2_even_bad");
    issue(8'h37, VERIFY_ODD, 1'b0, 1'b0, 1'b0);
    check_level("t2_odd_ok");
    clear_flags();
    check_flags("t2_cleared");
    drain("t2");

    // 3: bad second stop bit, clear held low in the finishing cycle.
    rd_en = 1'b0;
    fork
      issue(8'hC3, VERIFY_NONE, 1'b1, 1'b0, 1'b1);
      begin
        @(fall_ev);
        repeat (fin_cycles(VERIFY_NONE, 1'b1)) @(negedge i_clk);
        #1;
        i_clear_int_n = 1'b0;
        @(negedge i_clk);
        #1;
        i_clear_int_n = 1'b1;
        check("t3_set_beats_clear", o_err_frame, 1'b1);
      end
    join
    check_flags("t3");
    check_level("t3");
    clear_flags();
    check_flags("t3_cleared");

    // 4: short low glitch is a false start.
    @(negedge i_clk);
    #1;
    while (!i_tick) begin
      @(negedge i_clk);
      #1;
    end
    i_rx_data = 1'b0;
    repeat (4 * TDIV) @(negedge i_clk);
    #1;
    i_rx_data = 1'b1;
    repeat (4) @(negedge i_clk);
    #1;
    check("t4_busy_during", o_busy, 1'b1);
    repeat (BIT_CLK) @(negedge i_clk);
    #1;
    check("t4_busy_after", o_busy, 1'b0);
    check_flags("t4");
    check_level("t4");

    // Receive disabled: no start is accepted.
    i_ce_n = 1'b1;
    send_frame(8'h3C, VERIFY_NONE, 1'b0, 1'b0, 1'b0);
    check("ce_busy", o_busy, 1'b0);
    check_level("ce");
    i_ce_n = 1'b0;

    // 5: overrun on the ninth word, then simultaneous pop and push while full.
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      w = DATA_W'($urandom);
      issue(w, VERIFY_NONE, 1'b0, 1'b0, 1'b0);
    end
    check_flags("t5_full");
    check_level("t5_full");
    clear_flags();
    w    = DATA_W'($urandom);
    head = exp_q.pop_front();
    fork
      issue(w, VERIFY_NONE, 1'b0, 1'b0, 1'b0);
      begin
        @(fall_ev);
        repeat (fin_cycles(VERIFY_NONE, 1'b0)) @(negedge i_clk);
        #1;
        check("t5_head_at_pop", o_data, head);
        rd_b = 1'b1;
        @(negedge i_clk);
        #1;
        rd_b = 1'b0;
      end
    join
    check_flags("t5_pushpop");
    check_level("t5_pushpop");
    drain("t5");

    // Randomised frames with the monitor draining.
    for (int i = 0; i < 12; i++) begin
      logic [1:0] mode;
      mode = 2'($urandom_range(0, 3));
      issue(DATA_W'($urandom), mode, 1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0));
    end
    drain("rand");
    check_flags("rand");
    clear_flags();

    // 6: reset mid-DATA flushes the FIFO and abandons the frame.
    rd_en = 1'b0;
    issue(8'h11, VERIFY_NONE, 1'b0, 1'b0, 1'b0);
    check_level("t6_pre");
    fork
      issue(8'h99, VERIFY_NONE, 1'b0, 1'b0, 1'b0);
      begin
        @(fall_ev);
        repeat (3 * BIT_CLK) @(negedge i_clk);
        #1;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b1;
        check_reset_outputs("t6_reset");
      end
    join_any
    disable fork;
    i_rx_data = 1'b1;
    exp_q.delete();
    exp_par = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
    repeat (2 * BIT_CLK) @(negedge i_clk);
    issue(8'h5A, VERIFY_NONE, 1'b0, 1'b0, 1'b0);
    check_level("t6_post");
    drain("t6");
    check_flags("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/line_rx_fifo_ovs.md
Name: line_rx_fifo_ovs

Overview:
Parametrised oversampling asynchronous serial receiver. Recovers start/data/parity/stop framing from i_rx_data and buffers good words in a receive FIFO. Reports parity, framing and overrun errors as sticky flags and drives a level interrupt to the host-side register block. It is the successor to the fixed 8-bit line receiver and sits between the pad synchroniser domain and the CPU bus bridge.

Parameters:
DATA_W, 8, data bits per frame (legal 5..9), LSB first on the line
OVS, 16, i_tick strobes per bit period (even, >=4)
FIFO_DEPTH, 8, receive FIFO entries (power of 2, >=2)
INT_LEVEL, 1, FIFO level at or above which o_rx_int asserts (1..FIFO_DEPTH)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset; synchronous, active-low, sampled on the rising edge of i_clk
i_tick  in  1  oversample enable strobe, 1 i_clk cycle wide, OVS per bit
i_rx_data  in  1  serial line, asynchronous, idle high
i_verify_mode  in  2  00 even parity, 01 odd parity, 10/11 no parity
i_stop2  in  1  1 = two stop bits checked
i_ce_n  in  1  active-low receive enable
i_rd  in  1  FIFO pop strobe
i_clear_int_n  in  1  active-low clear of all sticky error flags
o_data  out  DATA_W  FIFO head word; 0 when empty
o_valid  out  1  FIFO non-empty
o_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
o_busy  out  1  FSM not in IDLE
o_err_parity / o_err_frame / o_err_overrun  out  1 each  sticky error flags
o_rx_int  out  1  (o_level >= INT_LEVEL) | any error flag

Behaviour:
- Input path: 2-flop synchroniser plus 1 history flop, all reset to 1. Start edge = history 1 and synchronised 0.
- Reset values: FSM IDLE; counters 0; FIFO empty; all error flags 0. Therefore o_data=0, o_valid=0, o_level=0, o_busy=0, o_rx_int=0.
- All sampling and counting advances only on cycles with i_tick=1. Tick counter width is clog2(OVS).
- IDLE: on a start edge with i_ce_n=0, go to START and clear the tick counter. Latch i_verify_mode and i_stop2 at the same time; both are held for the whole frame.
- START: at tick OVS/2-1, resample the line.
  - Line high: false start, return to IDLE, no flag set.
  - Line low: clear the counter and go to DATA.
- DATA: sample every OVS ticks (bit centre) into a shift register; bit counter runs 0..DATA_W-1. Then go to PARITY if the latched mode is 00/01, otherwise to STOP.
- PARITY: parity error when (^data ^ p) != latched_mode[0]. Even mode requires XOR = 0; odd mode requires XOR = 1.
- STOP: a sampled 0 sets the frame error. If latched stop2=1, go to STOP2 (same check), else finish. STOP2 finishes.
- Finish happens at the last stop-bit centre, with no wait for the bit end, so back-to-back frames are received. Return to IDLE.
  - Parity or frame error: word is discarded and the flag(s) set.
  - Otherwise: word is pushed to the FIFO.
- A line held low (break) yields a frame error. No new start is detected until the line returns high.
- i_ce_n=1 only blocks new starts. A frame already in progress completes.
- FIFO:
  - Push with the FIFO full and no pop: word dropped, o_err_overrun set, contents unchanged.
  - Push and pop in the same cycle when full: both occur, no overrun.
  - Pop when empty is ignored.
  - o_valid and o_level update 1 cycle after the push edge. Pointers wrap modulo FIFO_DEPTH.
- Error flags: set by events, cleared while i_clear_int_n=0. Set wins over a same-cycle clear.
- Reset mid-frame: the frame is abandoned and the FIFO is flushed.

Optional Feature:
Macro LINE_RX_MAJORITY_EN.
- Defined: each bit is decided by a 2-of-3 majority of the samples at ticks OVS/2-2, OVS/2-1 and OVS/2. The START false-start check uses the same vote.
- Undefined: single sample at tick OVS/2-1. No other difference in behaviour or interface.

Decomposition:
- Package line_rx_pkg holds:
  - verify-mode constants VERIFY_EVEN=2'b00, VERIFY_ODD=2'b01, VERIFY_NONE=2'b10
  - FSM state encoding IDLE/START/DATA/PARITY/STOP/STOP2
  - a clog2 helper function
- One sub-module, line_rx_sfifo: synchronous FIFO parametrised by width and depth, exposing push, pop, full, empty and level. The top level holds the synchroniser, FSM and error logic.

Test Plan:
1. OVS=16, DATA_W=8, mode 10, 1 stop; send 0xA5 -> o_valid=1 and o_data=0xA5 one cycle after the stop centre; no flags; o_rx_int=1.
2. Mode 00; send 0x37 with parity bit 1 -> pushed. Resend with parity bit 0 -> o_err_parity=1, level unchanged. Mode 01 with parity 0 -> accepted.
3. i_stop2=1, second stop bit driven 0 -> o_err_frame=1, word discarded. Pulse i_clear_int_n low -> flag clears unless a new error occurs in the same cycle.
4. Low glitch of 4 ticks on an idle line -> returns to IDLE, o_busy drops, no push, no flag.
5. Send 9 frames with no i_rd (FIFO_DEPTH=8) -> o_level=8, o_err_overrun=1, first 8 words intact. Then pop+push on the same cycle while full -> no new overrun.
6. Assert i_rst_n=0 mid-DATA -> next cycle all outputs at reset values. A subsequent frame 0x5A is received correctly.
